sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one single-port synchronous SRAM between the pipeline's instruction-fetch requester and data-access requester.
- Chosen so the CPU core can run from a unified memory.
- Data accesses have priority over fetches; a streak limiter prevents fetch starvation.
- Read data returns with fixed latency and is routed back to the owning requester.
- Sits between the CPU top level and the SRAM instance; the core stalls on a missing grant.

Parameters:
- ADDR_W, 32, address width of both requesters and the SRAM port.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending; legal range 1..15.

Ports:
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  in  1  fetch request; held until granted.
- inst_addr  in  ADDR_W  fetch address.
- inst_gnt  out  1  fetch accepted this cycle (combinational).
- inst_rvalid  out  1  inst_rdata valid (registered).
- inst_rdata  out  DATA_W  fetch data.
- data_req  in  1  data request; held until granted.
- data_we  in  DATA_W/8  byte write enables; all zero means read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_gnt  out  1  data access accepted this cycle (combinational).
- data_rvalid  out  1  data_rdata valid (registered).
- data_rdata  out  DATA_W  load data.
- sram_en  out  1  SRAM enable (registered).
- sram_wen  out  DATA_W/8  SRAM byte write enables (registered).
- sram_addr  out  ADDR_W  SRAM address (registered).
- sram_wdata  out  DATA_W  SRAM write data (registered).
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after sram_en.

Behaviour:
- Reset (resetn low, asynchronous):
  - sram_en, sram_wen, inst_rvalid, data_rvalid, streak counter and in-flight tags clear to 0.
  - sram_addr and sram_wdata clear to 0.
- Arbitration, at most one grant per cycle:
  - Only data_req set -> data_gnt.
  - Only inst_req set -> inst_gnt.
  - Both set -> data_gnt, unless streak == MAX_DATA_STREAK, in which case inst_gnt.
- Streak counter:
  - Increments on data_gnt while inst_req is high.
  - Clears on inst_gnt, or on any cycle inst_req is low.
  - Saturates at MAX_DATA_STREAK.
- Issue, cycle T+1 after grant at T:
  - sram_en=1; sram_addr/sram_wen/sram_wdata take the granted request's fields.
  - sram_wen=0 for fetches.
  - sram_en=0 in cycles with no grant.
- Tag pipeline: a 2-bit one-hot {inst, data} tag is registered with each issued read. Writes carry a zero tag.
- Response, cycle T+2:
  - Tagged owner's rvalid=1 for exactly one cycle.
  - Its rdata equals sram_rdata, passed through combinationally and qualified by rvalid.
  - The other rvalid stays 0.
- Read latency is 2 cycles from grant; back-to-back grants every cycle are allowed, giving full throughput.
- Writes produce no response; data_gnt is the completion.
- Read-after-write to the same address on consecutive grants returns the new data (SRAM order preserved).
- Withdrawing a request before grant is a protocol violation; the arbiter just re-evaluates each cycle, with no latching.
- Reset mid-operation: in-flight tags are discarded; no rvalid is produced for pre-reset grants.

Optional Feature:
- Macro SRAM_ARB_PERF_EN.
- When defined, adds three 32-bit saturating counters, cleared by reset, on outputs perf_inst_gnt, perf_data_gnt and perf_conflict:
  - perf_inst_gnt counts inst_gnt cycles.
  - perf_data_gnt counts data_gnt cycles.
  - perf_conflict counts cycles with both requests high.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - Tag encoding constants TAG_NONE=2'b00, TAG_INST=2'b01, TAG_DATA=2'b10.
  - Default ADDR_W/DATA_W.
  - Reset PC constant 32'hbfc00000, reused by the bench.
- One sub-module is natural: sram_arb_prio, the combinational grant logic plus streak counter.
- Issue registers, tag pipeline and perf counters stay in the top module.

Test Plan:
- Fetch-only stream: inst_req constant, addresses 0xbfc00000, +4, +8 -> inst_gnt every cycle; inst_rvalid 2 cycles later, in order, with matching preloaded data.
- Contention: both requests held 10 cycles, MAX_DATA_STREAK=4 -> grant pattern D,D,D,D,I repeating; streak never exceeds 4.
- Store then load to 0x100: data_we=4'b0011, wdata 0xAABBCCDD over prior 0x11223344, then read -> data_rdata=0x1122CCDD; no rvalid for the store.
- Interleaved fetch and load -> each rdata appears only on the owner's port; the other rvalid stays 0 that cycle.
- Assert resetn low with two reads in flight -> sram_en, both rvalid and all tags read 0 immediately; no rvalid after release.
- With SRAM_ARB_PERF_EN: 6 contention cycles (5 data, 1 inst grant) -> perf_conflict=6, perf_data_gnt=5, perf_inst_gnt=1.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the SRAM arbiter: read-response tags, default widths, reset PC.
package sram_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Boot address of the core; the fetch stream starts here out of reset.
    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    // One-hot owner of an in-flight read: bit 0 = fetch, bit 1 = data.
    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_INST = 2'b01,
        TAG_DATA = 2'b10
    } tag_e;

endpackage

// File: rtl/sram_arb_prio.sv
// Grant selection between fetch and data requesters, with a data-streak limiter
// that hands the port to a waiting fetch after MAX_DATA_STREAK data grants.
module sram_arb_prio #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic data_req,
    output logic inst_gnt,
    output logic data_gnt
);

    logic [3:0] streak_q;
    logic [3:0] streak_d;
    logic       streak_full;

    assign streak_full = (streak_q == 4'(MAX_DATA_STREAK));

    always_comb begin
        data_gnt = data_req && !(inst_req && streak_full);
        inst_gnt = inst_req && !data_gnt;
    end

    // The streak only measures how long a fetch has been kept waiting.
    always_comb begin
        streak_d = streak_q;
        if (inst_gnt || !inst_req) begin
            streak_d = '0;
        end else if (data_gnt && !streak_full) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data access.
// Optional perf counters are built when SRAM_ARB_PERF_EN is defined.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_gnt,
    output logic                  inst_rvalid,
    output logic [DATA_W-1:0]     inst_rdata,
    input  logic                  data_req,
    input  logic [DATA_W/8-1:0]   data_we,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_gnt,
    output logic                  data_rvalid,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  sram_en,
    output logic [DATA_W/8-1:0]   sram_wen,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_inst_gnt,
    output logic [31:0]           perf_data_gnt,
    output logic [31:0]           perf_conflict
`endif
);

    logic                sram_en_q,    sram_en_d;
    logic [DATA_W/8-1:0] sram_wen_q,   sram_wen_d;
    logic [ADDR_W-1:0]   sram_addr_q,  sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
    tag_e                tag_q,        tag_d;
    logic [1:0]          rvalid_q,     rvalid_d;

    sram_arb_prio #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_prio (
        .clk      (clk),
        .resetn   (resetn),
        .inst_req (inst_req),
        .data_req (data_req),
        .inst_gnt (inst_gnt),
        .data_gnt (data_gnt)
    );

    // Fetches never write; data writes carry no tag so they produce no response.
    always_comb begin
        sram_en_d    = inst_gnt || data_gnt;
        sram_wen_d   = '0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        tag_d        = TAG_NONE;
        rvalid_d     = tag_q;
        if (data_gnt) begin
            sram_wen_d   = data_we;
            sram_addr_d  = data_addr;
            sram_wdata_d = data_wdata;
            tag_d        = (data_we == '0) ? TAG_DATA : TAG_NONE;
        end else if (inst_gnt) begin
            sram_addr_d  = inst_addr;
            tag_d        = TAG_INST;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sram_en_q    <= 1'b0;
            sram_wen_q   <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            tag_q        <= TAG_NONE;
            rvalid_q     <= '0;
        end else begin
            sram_en_q    <= sram_en_d;
            sram_wen_q   <= sram_wen_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            tag_q        <= tag_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign sram_en     = sram_en_q;
    assign sram_wen    = sram_wen_q;
    assign sram_addr   = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;
    assign inst_rvalid = rvalid_q[0];
    assign data_rvalid = rvalid_q[1];
    assign inst_rdata  = inst_rvalid ? sram_rdata : '0;
    assign data_rdata  = data_rvalid ? sram_rdata : '0;

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perf_inst_q, perf_inst_d;
    logic [31:0] perf_data_q, perf_data_d;
    logic [31:0] perf_conf_q, perf_conf_d;

    always_comb begin
        perf_inst_d = perf_inst_q;
        perf_data_d = perf_data_q;
        perf_conf_d = perf_conf_q;
        if (inst_gnt && perf_inst_q != '1) perf_inst_d = perf_inst_q + 32'd1;
        if (data_gnt && perf_data_q != '1) perf_data_d = perf_data_q + 32'd1;
        if (inst_req && data_req && perf_conf_q != '1) perf_conf_d = perf_conf_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_inst_q <= '0;
            perf_data_q <= '0;
            perf_conf_q <= '0;
        end else begin
            perf_inst_q <= perf_inst_d;
            perf_data_q <= perf_data_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_inst_gnt = perf_inst_q;
    assign perf_data_gnt = perf_data_q;
    assign perf_conflict = perf_conf_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model, per-cycle reference model of grants/issue/responses,
// directed scenarios plus constrained-random traffic. Perf checks under SRAM_ARB_PERF_EN.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 4;

    logic          clk;
    logic          resetn;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_gnt;
    logic          inst_rvalid;
    logic [DW-1:0] inst_rdata;
    logic          data_req;
    logic [3:0]    data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_gnt;
    logic          data_rvalid;
    logic [DW-1:0] data_rdata;
    logic          sram_en;
    logic [3:0]    sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
`ifdef SRAM_ARB_PERF_EN
    logic [31:0]   perf_inst_gnt;
    logic [31:0]   perf_data_gnt;
    logic [31:0]   perf_conflict;
`endif

    sram_arbiter #(
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_DATA_STREAK (MAX)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata),
        .sram_en     (sram_en),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
`ifdef SRAM_ARB_PERF_EN
        .perf_inst_gnt (perf_inst_gnt),
        .perf_data_gnt (perf_data_gnt),
        .perf_conflict (perf_conflict),
`endif
        .sram_rdata  (sram_rdata)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'h5a5a_5a5a;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // ---------------- SRAM model (one-cycle read latency) ----------------
    logic [31:0] mem [logic [31:0]];
    initial sram_rdata = '0;
    always @(posedge clk) begin
        if (sram_en) begin
            logic [31:0] cur;
            cur = mem.exists(sram_addr) ? mem[sram_addr] : mem_default(sram_addr);
            if (sram_wen != 4'b0) mem[sram_addr] = merge(cur, sram_wdata, sram_wen);
            else sram_rdata <= cur;
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        gi;
        logic        gd;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] rd;
    } rec_t;

    rec_t        pipe[$];            // grant records of the last two cycles, newest last
    logic [31:0] shadow [logic [31:0]];
    int          streak_m;
    int          run_d;
    bit          last_gi, last_gd;
    bit          chk_en = 0;
    bit          pat_en = 0;
    logic [9:0]  pat;
    logic [DW-1:0] exp_q[$];         // inst_rdata seen in order (fetch test)
    logic [DW-1:0] dcap_q[$];
    int          pm_inst, pm_data, pm_conf;

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            if (!resetn) begin
                chk("rst_sram_en", 32'(sram_en), 32'd0);
                chk("rst_inst_rvalid", 32'(inst_rvalid), 32'd0);
                chk("rst_data_rvalid", 32'(data_rvalid), 32'd0);
                chk("rst_sram_addr", sram_addr, 32'd0);
                chk("rst_sram_wen", 32'(sram_wen), 32'd0);
                pipe.delete();
                streak_m = 0;
                run_d    = 0;
                last_gi  = 0;
                last_gd  = 0;
                pm_inst  = 0;
                pm_data  = 0;
                pm_conf  = 0;
            end else begin
                bit   egi, egd, eir, edr;
                rec_t p1, p2, r;
                egd = data_req && (!inst_req || streak_m < MAX);
                egi = inst_req && !egd;
                chk("inst_gnt", 32'(inst_gnt), 32'(egi));
                chk("data_gnt", 32'(data_gnt), 32'(egd));

                p1 = (pipe.size() >= 1) ? pipe[pipe.size()-1] : '0;
                p2 = (pipe.size() >= 2) ? pipe[pipe.size()-2] : '0;
                chk("sram_en", 32'(sram_en), 32'(p1.gi || p1.gd));
                if (p1.gi || p1.gd) begin
                    chk("sram_addr", sram_addr, p1.addr);
                    chk("sram_wen", 32'(sram_wen), 32'(p1.we));
                end
                if (p1.gd) chk("sram_wdata", sram_wdata, p1.wdata);

                eir = p2.gi;
                edr = p2.gd && (p2.we == 4'b0);
                chk("inst_rvalid", 32'(inst_rvalid), 32'(eir));
                chk("data_rvalid", 32'(data_rvalid), 32'(edr));
                chk("inst_rdata", inst_rdata, eir ? p2.rd : 32'd0);
                chk("data_rdata", data_rdata, edr ? p2.rd : 32'd0);

`ifdef SRAM_ARB_PERF_EN
                chk("perf_inst_gnt", perf_inst_gnt, 32'(pm_inst));
                chk("perf_data_gnt", perf_data_gnt, 32'(pm_data));
                chk("perf_conflict", perf_conflict, 32'(pm_conf));
`endif
                if (egi) pm_inst++;
                if (egd) pm_data++;
                if (inst_req && data_req) pm_conf++;

                // Observed data-grant run while a fetch waits must never exceed the limit.
                if (inst_req && data_gnt) run_d++;
                else run_d = 0;
                chk("streak_bound", 32'(run_d <= MAX), 32'd1);

                r = '0;
                r.gi = egi;
                r.gd = egd;
                if (egd) begin
                    r.addr  = data_addr;
                    r.we    = data_we;
                    r.wdata = data_wdata;
                end else if (egi) begin
                    r.addr = inst_addr;
                end
                if (egi || egd) begin
                    logic [31:0] cur;
                    cur = shadow.exists(r.addr) ? shadow[r.addr] : mem_default(r.addr);
                    if (r.we != 4'b0) shadow[r.addr] = merge(cur, r.wdata, r.we);
                    else r.rd = cur;
                end
                pipe.push_back(r);
                if (pipe.size() > 2) void'(pipe.pop_front());

                if (egi || !inst_req) streak_m = 0;
                else if (egd && streak_m < MAX) streak_m++;

                last_gi = egi;
                last_gd = egd;
                if (inst_rvalid) exp_q.push_back(inst_rdata);
                if (data_rvalid) dcap_q.push_back(data_rdata);
                if (pat_en) pat = {pat[8:0], data_gnt};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit ir, input logic [31:0] ia, input bit dr,
                         input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dwd);
        @(negedge clk);
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_we    = dwe;
        data_addr  = da;
        data_wdata = dwd;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 32'd0, 0, 4'd0, 32'd0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          pi, pd;
        logic [31:0] ia, da, dwd;
        logic [3:0]  dwe;

        resetn     = 1'b0;
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_we    = '0;
        data_addr  = '0;
        data_wdata = '0;
        pat        = '0;
        chk_en     = 1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // Fetch-only stream from the reset PC.
        exp_q.delete();
        drive(1, RESET_PC,        0, 4'd0, 32'd0, 32'd0);
        drive(1, RESET_PC + 32'd4, 0, 4'd0, 32'd0, 32'd0);
        drive(1, RESET_PC + 32'd8, 0, 4'd0, 32'd0, 32'd0);
        idle(4);
        chk("fetch_count", 32'(exp_q.size()), 32'd3);
        if (exp_q.size() == 3) begin
            chk("fetch_data0", exp_q[0], 32'he59a5a5a);
            chk("fetch_data1", exp_q[1], 32'he59a5a5e);
            chk("fetch_data2", exp_q[2], 32'he59a5a52);
        end

        // Contention: D,D,D,D,I repeating.
        idle(1);
        pat_en = 1;
        repeat (10) drive(1, 32'h40, 1, 4'd0, 32'h80, 32'd0);
        #3;
        pat_en = 0;
        chk("contention_pattern", 32'(pat), 32'(10'b1111011110));
        idle(3);

        // Store full word, partial store, then load.
        dcap_q.delete();
        drive(0, 32'd0, 1, 4'b1111, 32'h100, 32'h11223344);
        drive(0, 32'd0, 1, 4'b0011, 32'h100, 32'haabbccdd);
        drive(0, 32'd0, 1, 4'b0000, 32'h100, 32'd0);
        idle(4);
        chk("store_load_count", 32'(dcap_q.size()), 32'd1);
        if (dcap_q.size() == 1) chk("store_load_data", dcap_q[0], 32'h1122ccdd);

        // Interleaved fetch and load.
        drive(1, 32'h300, 1, 4'd0, 32'h104, 32'd0);
        drive(1, 32'h300, 0, 4'd0, 32'd0, 32'd0);
        drive(1, 32'h304, 1, 4'd0, 32'h108, 32'd0);
        drive(1, 32'h304, 0, 4'd0, 32'd0, 32'd0);
        drive(0, 32'd0,   1, 4'd0, 32'h100, 32'd0);
        idle(4);

        // Random traffic obeying hold-until-granted.
        pi = 0; pd = 0; ia = '0; da = '0; dwd = '0; dwe = '0;
        repeat (400) begin
            if (!pi || last_gi) begin
                pi = ($urandom_range(0, 99) < 55);
                ia = RESET_PC + 32'(4 * $urandom_range(0, 15));
            end
            if (!pd || last_gd) begin
                pd  = ($urandom_range(0, 99) < 55);
                da  = 32'h100 + 32'(4 * $urandom_range(0, 15));
                dwe = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                dwd = $urandom;
            end
            drive(pi, ia, pd, dwe, da, dwd);
            #3;
        end
        idle(4);

        // Reset with reads in flight.
        exp_q.delete();
        dcap_q.delete();
        drive(0, 32'd0,  1, 4'd0, 32'h100, 32'd0);
        drive(1, 32'h204, 0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        inst_req = 0;
        data_req = 0;
        resetn   = 1'b0;
        #1;
        chk("midrst_sram_en", 32'(sram_en), 32'd0);
        chk("midrst_rvalids", 32'({inst_rvalid, data_rvalid}), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        idle(4);
        chk("post_rst_inst_rv", 32'(exp_q.size()), 32'd0);
        chk("post_rst_data_rv", 32'(dcap_q.size()), 32'd0);

`ifdef SRAM_ARB_PERF_EN
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        repeat (6) drive(1, 32'h40, 1, 4'd0, 32'h80, 32'd0);
        idle(2);
        chk("perf_conflict_lit", perf_conflict, 32'd6);
        chk("perf_data_lit", perf_data_gnt, 32'd5);
        chk("perf_inst_lit", perf_inst_gnt, 32'd1);
`endif

        idle(3);
        #3;
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
